// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main controller: sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath.
// Optional performance counters are enabled by defining MCTRL_PERF_CNT_EN.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15
`ifdef MCTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_OPCode,
  input  logic             i_MemReady,
  output logic             o_PCWrite,
  output logic             o_IRWrite,
  output logic             o_IorD,
  output logic             o_Branch,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic             o_MemToReg,
  output logic [2:0]       o_ALUOp,
  output logic             o_ALUSrc1,
  output logic             o_ALUSrc2,
  output logic             o_RegWrite,
  output logic             o_IllegalInstr,
`ifdef MCTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] o_CycleCnt,
  output logic [CNT_W-1:0] o_InstRet,
`endif
  output logic             o_MemTimeout
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int WAIT_LAST = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
  localparam int WCNT_W    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP, ST_HALT
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  state_t              state_r, state_nxt_s;
  logic [6:0]          opc_r, opc_nxt_s;
  logic [WCNT_W-1:0]   wait_r, wait_nxt_s;
  logic                timeout_r, timeout_nxt_s;
  logic                wait_event_s;
  ctrl_t               ctrl_r;

  function automatic logic is_legal(input logic [6:0] opc);
    logic ok;
    case (opc)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU selection shared by EXEC and WB so the datapath result stays stable into writeback
  function automatic ctrl_t alu_ctrl(input logic [6:0] opc);
    ctrl_t c;
    c = '0;
    case (opc)
      OP_R:              c.alu_op = 3'b010;
      OP_I:              begin c.alu_op = 3'b011; c.alu_src2 = 1'b1; end
      OP_LOAD, OP_STORE: begin c.alu_op = 3'b000; c.alu_src2 = 1'b1; end
      OP_BRANCH:         c.alu_op = 3'b001;
      OP_LUI:            begin c.alu_op = 3'b100; c.alu_src2 = 1'b1; end
      OP_AUIPC:          begin c.alu_op = 3'b101; c.alu_src1 = 1'b1; c.alu_src2 = 1'b1; end
      default:           c = '0;
    endcase
    return c;
  endfunction

  function automatic ctrl_t decode(input state_t st, input logic [6:0] opc);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: c.mem_read = 1'b1;
      ST_EXEC: begin
        c = alu_ctrl(opc);
        c.branch = (opc == OP_BRANCH);
      end
      ST_MEM: begin
        c.iord      = 1'b1;
        c.mem_read  = (opc == OP_LOAD);
        c.mem_write = (opc == OP_STORE);
      end
      ST_WB: begin
        c = alu_ctrl(opc);
        c.reg_write  = 1'b1;
        c.mem_to_reg = (opc == OP_LOAD);
      end
      ST_TRAP: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign wait_event_s = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !i_MemReady;

  // Next-state, opcode latch and memory-stall watchdog
  always_comb begin
    state_nxt_s   = state_r;
    opc_nxt_s     = opc_r;
    wait_nxt_s    = wait_r;
    timeout_nxt_s = timeout_r;
    case (state_r)
      ST_RST:    state_nxt_s = ST_FETCH;
      ST_FETCH:  state_nxt_s = i_MemReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        opc_nxt_s   = i_OPCode;
        state_nxt_s = is_legal(i_OPCode) ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        if ((opc_r == OP_LOAD) || (opc_r == OP_STORE)) begin
          state_nxt_s = ST_MEM;
        end else if (opc_r == OP_BRANCH) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (i_MemReady) begin
          state_nxt_s = (opc_r == OP_LOAD) ? ST_WB : ST_FETCH;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB:     state_nxt_s = ST_FETCH;
      ST_TRAP:   state_nxt_s = ST_FETCH;
      ST_HALT:   state_nxt_s = ST_HALT;
      default:   state_nxt_s = ST_RST;
    endcase

    if (wait_event_s && (MEM_WAIT_MAX != 0)) begin
      if (wait_r == WCNT_W'(WAIT_LAST)) begin
        state_nxt_s   = ST_HALT;
        timeout_nxt_s = 1'b1;
        wait_nxt_s    = '0;
      end else begin
        wait_nxt_s = wait_r + WCNT_W'(1);
      end
    end else begin
      wait_nxt_s = '0;
    end
  end

  // State registers; strobes are registered from the decode of the state being entered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_RST;
      opc_r     <= 7'd0;
      wait_r    <= '0;
      timeout_r <= 1'b0;
      ctrl_r    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      opc_r     <= opc_nxt_s;
      wait_r    <= wait_nxt_s;
      timeout_r <= timeout_nxt_s;
      ctrl_r    <= decode(state_nxt_s, opc_nxt_s);
    end
  end

  // IR/PC load must coincide with the cycle the fetch completes
  assign o_IRWrite      = (state_r == ST_FETCH) && i_MemReady;
  assign o_PCWrite      = (state_r == ST_FETCH) && i_MemReady;
  assign o_IorD         = ctrl_r.iord;
  assign o_Branch       = ctrl_r.branch;
  assign o_MemRead      = ctrl_r.mem_read;
  assign o_MemWrite     = ctrl_r.mem_write;
  assign o_MemToReg     = ctrl_r.mem_to_reg;
  assign o_ALUOp        = ctrl_r.alu_op;
  assign o_ALUSrc1      = ctrl_r.alu_src1;
  assign o_ALUSrc2      = ctrl_r.alu_src2;
  assign o_RegWrite     = ctrl_r.reg_write;
  assign o_IllegalInstr = ctrl_r.illegal;
  assign o_MemTimeout   = timeout_r;

`ifdef MCTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_r, inst_ret_r;
  logic             retire_s;

  assign retire_s = (state_r == ST_WB)
                 || ((state_r == ST_MEM) && (opc_r == OP_STORE) && i_MemReady)
                 || ((state_r == ST_EXEC) && (opc_r == OP_BRANCH));

  // Free-running cycle and retired-instruction counters, wrapping naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt_r <= '0;
      inst_ret_r  <= '0;
    end else begin
      if ((state_r != ST_RST) && (state_r != ST_HALT)) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      end
      if (retire_s) begin
        inst_ret_r <= inst_ret_r + CNT_W'(1);
      end
    end
  end

  assign o_CycleCnt = cycle_cnt_r;
  assign o_InstRet  = inst_ret_r;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expected strobes, a monitor compares them.
module tb_multicycle_control;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, ir_write, iord, branch, mem_read, mem_write, mem_to_reg;
  logic [2:0] alu_op;
  logic       alu_src1, alu_src2, reg_write, illegal, timeout;
`ifdef MCTRL_PERF_CNT_EN
  logic [3:0] cycle_cnt, inst_ret;
`endif

  always #5 clk = ~clk;

  multicycle_control #(
    .MEM_WAIT_MAX(15)
`ifdef MCTRL_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_OPCode(opcode), .i_MemReady(mem_ready),
    .o_PCWrite(pc_write), .o_IRWrite(ir_write), .o_IorD(iord), .o_Branch(branch),
    .o_MemRead(mem_read), .o_MemWrite(mem_write), .o_MemToReg(mem_to_reg),
    .o_ALUOp(alu_op), .o_ALUSrc1(alu_src1), .o_ALUSrc2(alu_src2),
    .o_RegWrite(reg_write), .o_IllegalInstr(illegal),
`ifdef MCTRL_PERF_CNT_EN
    .o_CycleCnt(cycle_cnt), .o_InstRet(inst_ret),
`endif
    .o_MemTimeout(timeout)
  );

  // Vector layout: pcw irw iord br mr mw m2r aluop[2:0] s1 s2 rw ill to
  function automatic logic [14:0] mk(input logic pcw, input logic irw, input logic io,
                                     input logic br, input logic mr, input logic mw,
                                     input logic m2r, input logic [2:0] op, input logic s1,
                                     input logic s2, input logic rw, input logic ill,
                                     input logic to);
    return {pcw, irw, io, br, mr, mw, m2r, op, s1, s2, rw, ill, to};
  endfunction

  logic [14:0] obs;
  assign obs = {pc_write, ir_write, iord, branch, mem_read, mem_write, mem_to_reg,
                alu_op, alu_src1, alu_src2, reg_write, illegal, timeout};

  logic [14:0] v_zero, v_fw, v_fr, v_ex_r, v_wb_r, v_ex_i, v_wb_i, v_ex_ls, v_mem_ld,
               v_wb_ld, v_mem_st, v_ex_br, v_ex_lui, v_wb_lui, v_ex_aui, v_wb_aui,
               v_trap, v_halt;

  logic [14:0] exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [14:0] mon_exp;
  string       mon_name;

  // Monitor: one expected vector per cycle, compared away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      n_tests++;
      if (obs !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", mon_name, obs, mon_exp);
      end
    end
  end

  task automatic push(input logic [14:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input logic [6:0] opc, input logic rdy, input logic [14:0] e,
                      input string nm);
    @(posedge clk);
    #1;
    opcode    = opc;
    mem_ready = rdy;
    push(e, nm);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(v_zero, "rst_state");
  endtask

  task automatic run_add(input string tag);
    step(OP_R, 1'b1, v_fr,   {tag, "_fetch"});
    step(OP_R, 1'b1, v_zero, {tag, "_decode"});
    step(OP_R, 1'b1, v_ex_r, {tag, "_exec"});
    step(OP_R, 1'b1, v_wb_r, {tag, "_wb"});
  endtask

  initial begin
    v_zero   = 15'd0;
    v_fw     = mk(0,0,0,0,1,0,0,3'b000,0,0,0,0,0);
    v_fr     = mk(1,1,0,0,1,0,0,3'b000,0,0,0,0,0);
    v_ex_r   = mk(0,0,0,0,0,0,0,3'b010,0,0,0,0,0);
    v_wb_r   = mk(0,0,0,0,0,0,0,3'b010,0,0,1,0,0);
    v_ex_i   = mk(0,0,0,0,0,0,0,3'b011,0,1,0,0,0);
    v_wb_i   = mk(0,0,0,0,0,0,0,3'b011,0,1,1,0,0);
    v_ex_ls  = mk(0,0,0,0,0,0,0,3'b000,0,1,0,0,0);
    v_mem_ld = mk(0,0,1,0,1,0,0,3'b000,0,0,0,0,0);
    v_wb_ld  = mk(0,0,0,0,0,0,1,3'b000,0,1,1,0,0);
    v_mem_st = mk(0,0,1,0,0,1,0,3'b000,0,0,0,0,0);
    v_ex_br  = mk(0,0,0,1,0,0,0,3'b001,0,0,0,0,0);
    v_ex_lui = mk(0,0,0,0,0,0,0,3'b100,0,1,0,0,0);
    v_wb_lui = mk(0,0,0,0,0,0,0,3'b100,0,1,1,0,0);
    v_ex_aui = mk(0,0,0,0,0,0,0,3'b101,1,1,0,0,0);
    v_wb_aui = mk(0,0,0,0,0,0,0,3'b101,1,1,1,0,0);
    v_trap   = mk(0,0,0,0,0,0,0,3'b000,0,0,0,1,0);
    v_halt   = mk(0,0,0,0,0,0,0,3'b000,0,0,0,0,1);

    rst_n     = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b1;
    #2;
    push(v_zero, "in_reset");
    @(negedge clk);
    release_reset();

    run_add("add");

    step(OP_I, 1'b1, v_fr,   "addi_fetch");
    step(OP_I, 1'b1, v_zero, "addi_decode");
    step(OP_I, 1'b1, v_ex_i, "addi_exec");
    step(OP_I, 1'b1, v_wb_i, "addi_wb");

    // Load with three memory wait cycles: eight cycles in total
    step(OP_LOAD, 1'b1, v_fr,    "lw_fetch");
    step(OP_LOAD, 1'b1, v_zero,  "lw_decode");
    step(OP_LOAD, 1'b1, v_ex_ls, "lw_exec");
    for (int i = 0; i < 3; i++) step(OP_LOAD, 1'b0, v_mem_ld, "lw_mem_wait");
    step(OP_LOAD, 1'b1, v_mem_ld, "lw_mem_done");
    step(OP_LOAD, 1'b1, v_wb_ld,  "lw_wb");

    step(OP_STORE, 1'b1, v_fr,     "sw_fetch");
    step(OP_STORE, 1'b1, v_zero,   "sw_decode");
    step(OP_STORE, 1'b1, v_ex_ls,  "sw_exec");
    step(OP_STORE, 1'b1, v_mem_st, "sw_mem");
    step(OP_BRANCH, 1'b1, v_fr,    "beq_fetch");
    step(OP_BRANCH, 1'b1, v_zero,  "beq_decode");
    step(OP_BRANCH, 1'b1, v_ex_br, "beq_exec");

    step(OP_LUI, 1'b0, v_fw,     "lui_fetch_wait");
    step(OP_LUI, 1'b1, v_fr,     "lui_fetch");
    step(OP_LUI, 1'b1, v_zero,   "lui_decode");
    step(OP_LUI, 1'b1, v_ex_lui, "lui_exec");
    step(OP_LUI, 1'b1, v_wb_lui, "lui_wb");

    step(OP_AUIPC, 1'b1, v_fr,     "auipc_fetch");
    step(OP_AUIPC, 1'b1, v_zero,   "auipc_decode");
    step(OP_AUIPC, 1'b1, v_ex_aui, "auipc_exec");
    step(OP_AUIPC, 1'b1, v_wb_aui, "auipc_wb");

    step(OP_BAD, 1'b1, v_fr,   "bad_fetch");
    step(OP_BAD, 1'b1, v_zero, "bad_decode");
    step(OP_BAD, 1'b1, v_trap, "bad_trap");
    run_add("after_trap");

    // Fetch stalls forever: 15 wait cycles, then HALT with sticky timeout
    for (int i = 0; i < 15; i++) step(OP_R, 1'b0, v_fw, "stall_fetch");
    step(OP_R, 1'b0, v_halt, "halt_1");
    step(OP_R, 1'b1, v_halt, "halt_2");
    step(OP_R, 1'b1, v_halt, "halt_3");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push(v_zero, "halt_reset");
    release_reset();

    // Reset mid-fetch must drop the read request within the same cycle
    step(OP_R, 1'b0, v_fw, "mid_fetch_1");
    step(OP_R, 1'b0, v_fw, "mid_fetch_2");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push(v_zero, "mid_fetch_reset");
    release_reset();
    run_add("post_reset_add");

`ifdef MCTRL_PERF_CNT_EN
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push(v_zero, "perf_reset");
    release_reset();
    for (int i = 0; i < 20; i++) run_add("perf_add");
    @(posedge clk);
    #2;
    n_tests++;
    if (inst_ret !== 4'd4) begin
      n_fail++;
      $display("FAIL inst_ret: got %0d expected 4", inst_ret);
    end
    n_tests++;
    if (cycle_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL cycle_cnt: got %0d expected 0", cycle_cnt);
    end
`endif

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
